// File: rtl/port_alloc_sched.sv
// Fair-priority wrapper around the parallel port allocator: rotating golden
// pointer, optional starvation override (STARVE_OVERRIDE_EN), 2-stage pipe.
// Ports: clk, reset (async, active-low), sched_en, in_valid/in_pv (channel
// order), alloc_valid/alloc_pv -> allocator, alloc_pv_out <- allocator (slot
// order), out_valid/out_pv (registered, channel order), golden_ptr, starved.
module port_alloc_sched #(
  parameter int NUM_CH     = 5,
  parameter int W_PV       = 5,
  parameter int NUM_PORT   = 6,
  parameter int EPOCH_LEN  = 16,
  parameter int STARVE_MAX = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sched_en,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*W_PV-1:0]     in_pv,
  output logic [NUM_CH-1:0]          alloc_valid,
  output logic [NUM_CH*W_PV-1:0]     alloc_pv,
  input  logic [NUM_CH*NUM_PORT-1:0] alloc_pv_out,
  output logic [NUM_CH-1:0]          out_valid,
  output logic [NUM_CH*NUM_PORT-1:0] out_pv,
  output logic [2:0]                 golden_ptr,
  output logic [NUM_CH-1:0]          starved
);

  localparam int EW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

  logic [NUM_CH-1:0]          r_s1_valid;
  logic [NUM_CH*W_PV-1:0]     r_s1_pv;
  logic [NUM_CH-1:0]          r_out_valid;
  logic [NUM_CH*NUM_PORT-1:0] r_out_pv;
  logic [EW-1:0]              r_epoch;
  logic [2:0]                 r_gptr;

  logic [2:0]                 w_map [NUM_CH];
  logic [2:0]                 w_walk;
  logic [2:0]                 w_force;
  logic                       w_force_hit;
  logic [NUM_CH-1:0]          w_starved;
  logic [NUM_CH*NUM_PORT-1:0] w_grant;

  function automatic logic [2:0] f_inc(input logic [2:0] x);
    return (x == 3'(NUM_CH - 1)) ? 3'd0 : x + 3'd1;
  endfunction

`ifdef STARVE_OVERRIDE_EN
  logic [2:0] r_cnt [NUM_CH];

  // A grant with no real output port (BYPASS or nothing) is non-productive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else if (sched_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_s1_valid[i] &&
            w_grant[i*NUM_PORT +: W_PV] == '0) begin
          if (r_cnt[i] != 3'(STARVE_MAX))
            r_cnt[i] <= r_cnt[i] + 3'd1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_starved[i] = (r_cnt[i] == 3'(STARVE_MAX));
  end

  // Descending scan so the lowest-index starved channel wins.
  always_comb begin
    w_force_hit = 1'b0;
    w_force     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_starved[i] && r_s1_valid[i]) begin
        w_force_hit = 1'b1;
        w_force     = 3'(i);
      end
    end
  end
`else
  assign w_starved   = '0;
  assign w_force_hit = 1'b0;
  assign w_force     = '0;
`endif

  // Slot -> channel map. The forced channel takes slot 0 and is skipped
  // while walking the rotation from the golden pointer.
  always_comb begin
    w_walk = r_gptr;
    for (int k = 0; k < NUM_CH; k++) w_map[k] = 3'(k);
    if (sched_en) begin
      if (w_force_hit) begin
        w_map[0] = w_force;
        for (int k = 1; k < NUM_CH; k++) begin
          if (w_walk == w_force) w_walk = f_inc(w_walk);
          w_map[k] = w_walk;
          w_walk   = f_inc(w_walk);
        end
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          w_map[k] = w_walk;
          w_walk   = f_inc(w_walk);
        end
      end
    end
  end

  always_comb begin
    alloc_valid = '0;
    alloc_pv    = '0;
    w_grant     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      alloc_valid[k] = r_s1_valid[w_map[k]];
      alloc_pv[k*W_PV +: W_PV] =
        r_s1_pv[int'(w_map[k])*W_PV +: W_PV];
      w_grant[int'(w_map[k])*NUM_PORT +: NUM_PORT] =
        alloc_pv_out[k*NUM_PORT +: NUM_PORT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= '0;
      r_s1_pv     <= '0;
      r_out_valid <= '0;
      r_out_pv    <= '0;
    end else begin
      r_s1_valid  <= in_valid;
      r_s1_pv     <= in_pv;
      r_out_valid <= r_s1_valid;
      for (int i = 0; i < NUM_CH; i++)
        r_out_pv[i*NUM_PORT +: NUM_PORT] <= r_s1_valid[i] ?
          w_grant[i*NUM_PORT +: NUM_PORT] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epoch <= '0;
      r_gptr  <= '0;
    end else if (sched_en) begin
      if (r_epoch == EW'(EPOCH_LEN - 1)) begin
        r_epoch <= '0;
        r_gptr  <= f_inc(r_gptr);
      end else begin
        r_epoch <= r_epoch + EW'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pv     = r_out_pv;
  assign golden_ptr = r_gptr;
  assign starved    = w_starved;

endmodule

// File: tb/tb_port_alloc_sched.sv
// Self-checking bench for port_alloc_sched with a behavioural allocator,
// a vector table, directed corner sequences and a random reference check.
module tb_port_alloc_sched;

  localparam int EL = 4;
  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sched_en = 1'b0;
  logic [4:0]  in_valid = '0;
  logic [24:0] in_pv = '0;
  logic [4:0]  alloc_valid;
  logic [24:0] alloc_pv;
  logic [29:0] alloc_pv_out;
  logic [4:0]  out_valid;
  logic [29:0] out_pv;
  logic [2:0]  golden_ptr;
  logic [4:0]  starved;

  int n_cmp = 0;
  int n_bad = 0;

  port_alloc_sched #(
    .NUM_CH(5), .W_PV(5), .NUM_PORT(6),
    .EPOCH_LEN(EL), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en),
    .in_valid(in_valid), .in_pv(in_pv),
    .alloc_valid(alloc_valid), .alloc_pv(alloc_pv),
    .alloc_pv_out(alloc_pv_out),
    .out_valid(out_valid), .out_pv(out_pv),
    .golden_ptr(golden_ptr), .starved(starved)
  );

  always #5 clk = ~clk;

  // Allocator stand-in: slot 0 first, lowest free requested port, else BYPASS.
  logic [4:0] a_used, a_req, a_one;
  always_comb begin
    a_used = '0;
    a_req = '0;
    a_one = '0;
    alloc_pv_out = '0;
    for (int k = 0; k < 5; k++) begin
      if (alloc_valid[k]) begin
        a_req = alloc_pv[k*5 +: 5] & ~a_used;
        a_one = a_req & (~a_req + 5'd1);
        if (a_req == '0) alloc_pv_out[k*6 +: 6] = 6'h20;
        else alloc_pv_out[k*6 +: 6] = {1'b0, a_one};
        a_used = a_used | a_one;
      end
    end
  end

  // Reference model, channel-level view.
  int       m_g, m_ep;
  int       m_cnt [5];
  bit [4:0] m_s1v;
  bit [4:0] m_s1pv [5];
  bit [4:0] m_ov;
  bit [5:0] m_opv [5];

  function automatic void m_reset();
    m_g = 0; m_ep = 0; m_s1v = '0; m_ov = '0;
    for (int c = 0; c < 5; c++) begin
      m_cnt[c] = 0; m_s1pv[c] = '0; m_opv[c] = '0;
    end
  endfunction

  function automatic void m_step(bit en, bit [4:0] v, bit [24:0] pv);
    int ord[$];
    int f;
    bit [4:0] used;
    bit [5:0] gr [5];
    bit found;
    f = -1;
    if (en) begin
`ifdef STARVE_OVERRIDE_EN
      for (int c = 0; c < 5; c++)
        if (f < 0 && m_cnt[c] == SM && m_s1v[c]) f = c;
`endif
      if (f >= 0) ord.push_back(f);
      for (int k = 0; k < 5; k++)
        if ((m_g + k) % 5 != f) ord.push_back((m_g + k) % 5);
    end else begin
      for (int k = 0; k < 5; k++) ord.push_back(k);
    end
    used = '0;
    for (int c = 0; c < 5; c++) gr[c] = '0;
    foreach (ord[i]) begin
      if (m_s1v[ord[i]]) begin
        gr[ord[i]] = 6'h20;
        found = 1'b0;
        for (int b = 0; b < 5; b++) begin
          if (!found && m_s1pv[ord[i]][b] && !used[b]) begin
            found = 1'b1;
            used[b] = 1'b1;
            gr[ord[i]] = 6'(1 << b);
          end
        end
      end
    end
    if (en) begin
      for (int c = 0; c < 5; c++) begin
        if (m_s1v[c] && gr[c][4:0] == 0)
          m_cnt[c] = (m_cnt[c] < SM) ? m_cnt[c] + 1 : SM;
        else
          m_cnt[c] = 0;
      end
      if (m_ep == EL - 1) begin
        m_ep = 0;
        m_g = (m_g + 1) % 5;
      end else begin
        m_ep = m_ep + 1;
      end
    end
    m_ov = m_s1v;
    for (int c = 0; c < 5; c++) m_opv[c] = m_s1v[c] ? gr[c] : 6'h0;
    m_s1v = v;
    for (int c = 0; c < 5; c++) m_s1pv[c] = pv[c*5 +: 5];
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic check_model(string tag);
    bit [29:0] e;
    bit [4:0] es;
    es = '0;
    for (int c = 0; c < 5; c++) e[c*6 +: 6] = m_opv[c];
`ifdef STARVE_OVERRIDE_EN
    for (int c = 0; c < 5; c++) es[c] = (m_cnt[c] == SM);
`endif
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_pv"}, 32'(out_pv), 32'(e));
    chk({tag, ".golden_ptr"}, 32'(golden_ptr), 32'(m_g));
    chk({tag, ".starved"}, 32'(starved), 32'(es));
  endtask

  task automatic tick(string tag);
    m_step(sched_en, in_valid, in_pv);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst.async_out_valid", 32'(out_valid), 32'd0);
    chk("rst.async_out_pv", 32'(out_pv), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic bit [29:0] one_win(int w);
    bit [29:0] r;
    for (int c = 0; c < 5; c++) r[c*6 +: 6] = (c == w) ? 6'h01 : 6'h20;
    return r;
  endfunction

  typedef struct {
    bit [4:0]  v;
    bit [24:0] pv;
    bit [29:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'h1F, {5{5'b00001}},
               {6'h20, 6'h20, 6'h20, 6'h20, 6'h01}};
    tbl[1] = '{5'b01000,
               {5'b11111, 5'b00100, 5'b11111, 5'b11111, 5'b11111},
               {6'h00, 6'h04, 6'h00, 6'h00, 6'h00}};
    tbl[2] = '{5'h1F,
               {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001},
               {6'h10, 6'h08, 6'h04, 6'h02, 6'h01}};
    tbl[3] = '{5'b00011, {15'b0, 5'b01000, 5'b11000},
               {6'h00, 6'h00, 6'h00, 6'h20, 6'h08}};
    tbl[4] = '{5'b00000, {5{5'b11111}}, 30'h0};
    tbl[5] = '{5'b10101,
               {5'b00011, 5'b0, 5'b00011, 5'b0, 5'b00011},
               {6'h20, 6'h00, 6'h02, 6'h00, 6'h01}};

    // Reset held with live inputs.
    m_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 5'($urandom);
      in_pv = 25'($urandom);
      sched_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_pv", 32'(out_pv), 32'd0);
      chk("rst.golden_ptr", 32'(golden_ptr), 32'd0);
      chk("rst.starved", 32'(starved), 32'd0);
    end
    in_valid = '0;
    in_pv = '0;
    @(negedge clk);
    reset = 1'b1;
    tick("idle");
    tick("idle");
    in_valid = 5'b01000;
    in_pv = 25'(5'b00100) << 15;
    tick("lat1");
    chk("lat.edge1", 32'(out_pv), 32'd0);
    in_valid = '0;
    tick("lat2");
    chk("lat.edge2", 32'(out_pv), 32'(30'(6'h04) << 18));

    // Identity mapping table.
    sched_en = 1'b0;
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_pv = tbl[i].pv;
      tick("tbl");
      tick("tbl");
      chk($sformatf("tbl%0d.out_pv", i), 32'(out_pv), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid),
          32'(tbl[i].v));
    end

    // Rotation: all channels contend for port 0.
    do_reset();
    sched_en = 1'b1;
    in_valid = 5'h1F;
    in_pv = {5{5'b00001}};
    for (int n = 1; n <= 24; n++) begin
      tick("rot");
      chk($sformatf("rot%0d.golden", n), 32'(golden_ptr),
          32'((n / EL) % 5));
`ifndef STARVE_OVERRIDE_EN
      if (n >= 2)
        chk($sformatf("rot%0d.winner", n), 32'(out_pv),
            32'(one_win(((n - 1) / EL) % 5)));
`endif
    end

    // Starvation: channels 1 and 2 contend; channel 1 ahead for two epochs.
    do_reset();
    sched_en = 1'b1;
    in_valid = 5'b00110;
    in_pv = {15'b0, 5'b00001, 5'b00001, 5'b0};
    for (int n = 1; n <= 9; n++) begin
      tick("stv");
      if (n >= 2 && n <= 4) begin
        chk($sformatf("stv%0d.ch2", n), 32'(out_pv[12 +: 6]), 32'h20);
        chk($sformatf("stv%0d.ch1", n), 32'(out_pv[6 +: 6]), 32'h01);
      end
`ifdef STARVE_OVERRIDE_EN
      if (n == 3)
        chk("stv3.starved", 32'(starved), 32'd0);
      if (n == 4)
        chk("stv4.starved", 32'(starved), 32'b00100);
      if (n == 5) begin
        chk("stv5.ch2", 32'(out_pv[12 +: 6]), 32'h01);
        chk("stv5.ch1", 32'(out_pv[6 +: 6]), 32'h20);
        chk("stv5.starved", 32'(starved), 32'd0);
      end
`else
      chk($sformatf("stv%0d.starved", n), 32'(starved), 32'd0);
      if (n >= 5 && n <= 8)
        chk($sformatf("stv%0d.ch2", n), 32'(out_pv[12 +: 6]), 32'h20);
      if (n == 9)
        chk("stv9.ch2", 32'(out_pv[12 +: 6]), 32'h01);
`endif
    end

    // Random traffic against the model, with occasional mid-run reset.
    for (int n = 0; n < 600; n++) begin
      sched_en = ($urandom_range(7) != 0);
      in_valid = 5'($urandom);
      for (int c = 0; c < 5; c++)
        in_pv[c*5 +: 5] = ($urandom_range(3) == 0) ?
          5'($urandom) : 5'(1 << $urandom_range(1));
      if ($urandom_range(99) == 0) do_reset();
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/port_alloc_sched.md
Name: port_alloc_sched

Overview:
- Cycle-level scheduler wrapped around the combinational parallel port allocator of the deflection router.
- The allocator gives strict priority by slot index (slot 0 highest). This block assigns router channels to allocator slots using a rotating "golden" pointer and a starvation override, so priority is shared fairly.
- Registers incoming flit port vectors, drives the allocator with permuted vectors, un-permutes its result, and registers the final per-channel port vectors for the crossbar stage.

Parameters:
NUM_CH, 5, number of input channels / allocator slots (fixed at 5 by the allocator)
W_PV, 5, width of one requested port vector
NUM_PORT, 6, width of one granted port vector; bit 5 = BYPASS
EPOCH_LEN, 16, cycles per golden-pointer epoch (>=1)
STARVE_MAX, 7, consecutive non-productive grants before a channel is forced to slot 0 (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
sched_en  in  1  1 = rotate/override; 0 = identity mapping, pointer and counters hold
in_valid  in  NUM_CH  flit present per channel
in_pv  in  NUM_CH*W_PV  requested port vector per channel, channel i at [i*W_PV +: W_PV]
alloc_valid  out  NUM_CH  to allocator validVector, slot-ordered
alloc_pv  out  NUM_CH*W_PV  to allocator PVIn, slot-ordered
alloc_pv_out  in  NUM_CH*NUM_PORT  from allocator PVOut, slot-ordered
out_valid  out  NUM_CH  registered, channel-ordered
out_pv  out  NUM_CH*NUM_PORT  registered granted vector, channel-ordered
golden_ptr  out  3  current golden channel, 0..4
starved  out  NUM_CH  channel counter == STARVE_MAX

Behaviour:
- Reset (reset=0, async): S1 registers, out_valid, out_pv, epoch counter, golden_ptr and all starve counters = 0; starved = 0.
- Stage S1: every clk edge, in_valid/in_pv are captured into S1. No backpressure; a flit is never dropped.
- Mapping (combinational from S1 and state):
  - sched_en=0: slot k = channel k.
  - sched_en=1, no forced channel: slot k = channel (golden_ptr+k) mod 5.
  - Forced channel f (see optional feature): slot 0 = f; slots 1..4 = channels golden_ptr, golden_ptr+1, ... mod 5, skipping f.
  - Mapping is a bijection; slot and channel arrays are indexed with the same map both ways.
- alloc_valid/alloc_pv = S1 contents in slot order.
- Stage S2: at the next edge, alloc_pv_out is un-permuted to channel order and registered into out_pv; out_valid is S1 valid.
  - Invalid channel: out_pv = 0.
  - Latency: inputs sampled at edge t appear on out_pv after edge t+1, i.e. 2 edges.
- Epoch counter (sched_en=1): increments each cycle.
  - At EPOCH_LEN-1 it wraps to 0 and golden_ptr advances (4 wraps to 0).
  - EPOCH_LEN=1: advances every cycle.
- Mapping and the registered grant always use the same pointer value. A pointer change takes effect on the allocation of the following cycle.
- sched_en=0: epoch counter, golden_ptr and starve counters hold their values.
- Reset mid-operation: any in-flight S1/S2 contents are discarded; outputs read 0 until two edges after reset release.

Optional Feature:
Macro STARVE_OVERRIDE_EN.
- Defined:
  - Per-channel 3-bit saturating counter, updated at the S2 edge.
  - The counter increments when the channel is valid and its granted vector is BYPASS (6'b100000) or 0.
  - It clears when the channel is invalid or receives a productive port (bits[4:0] nonzero). It saturates at STARVE_MAX.
  - starved[i] = (cnt[i]==STARVE_MAX).
  - Forced channel f = lowest-index channel with starved set and valid in S1. f clears on its next productive grant.
- Undefined: no counters; starved = 0; pure rotation mapping.

Test Plan:
- Reset: hold reset=0 with random inputs -> out_pv=0, out_valid=0, golden_ptr=0, starved=0; release -> first non-zero out_pv exactly 2 edges after first valid input.
- Identity: sched_en=0, all five channels request port vector 5'b00001 -> channel 0 out_pv=6'b000001; channel 1 out_pv=6'b100000.
- Rotation: sched_en=1, EPOCH_LEN=4, all five request 5'b00001 every cycle -> golden_ptr steps 0,1,2,3,4,0 every 4 cycles; the contested port goes to channel golden_ptr.
- Single flit: only channel 3 valid, pv 5'b00100, any golden_ptr -> out_pv[3]=6'b000100; other channels 0.
- Starvation (macro on, STARVE_MAX=3, EPOCH_LEN=16, golden_ptr=0): channels 0 and 2 both request 5'b00001 every cycle -> channel 2 BYPASS 3 times, starved[2]=1, next allocation channel 2 gets 6'b000001, counter clears.
- Macro off, same stimulus -> channel 2 BYPASS until the epoch rotates golden_ptr; starved stays 0.
